// File: rtl/interrupt_gen.sv
// interrupt_gen: MSI request generator for the PCIe endpoint cfg_interrupt port.
// Merges rate-limited, host-gated data-ready events with unconditional resend
// requests from hw_sw_synch, and acks resends once the core accepts the MSI.
module interrupt_gen #(
  parameter int unsigned HOLDOFF_CYCLES = 256
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        hw_event,
  input  logic        interrupts_enabled,
  input  logic        resend_interrupt,
  output logic        resend_interrupt_ack,
  input  logic        cfg_interrupt_msienable,
  input  logic        cfg_interrupt_rdy_n,
  output logic        cfg_interrupt_n,
  output logic        cfg_interrupt_assert_n,
  output logic [7:0]  cfg_interrupt_di,
  output logic [31:0] interrupt_count
);

  localparam logic [15:0] HoldoffLoad = 16'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGuard
  } state_e;

  state_e      state_q, state_d;
  logic        cfg_int_n_q, cfg_int_n_d;
  logic        ack_q, ack_d;
  logic        resend_svc_q, resend_svc_d;
  logic        pending_q, pending_d;
  logic [15:0] holdoff_q, holdoff_d;
  logic [31:0] count_q;

  logic accept;
  logic launch;

  // Legacy INTx is unused and only MSI vector 0 is ever requested.
  assign cfg_interrupt_assert_n = 1'b1;
  assign cfg_interrupt_di       = 8'h00;

  assign cfg_interrupt_n      = cfg_int_n_q;
  assign resend_interrupt_ack = ack_q;
  assign interrupt_count      = count_q;

  assign accept = (state_q == StReq) && !cfg_interrupt_rdy_n;

  // Resend ignores both hold-off and the host enable; MSI enable gates everything.
  assign launch = (state_q == StIdle) && cfg_interrupt_msienable &&
                  (resend_interrupt ||
                   (pending_q && interrupts_enabled && (holdoff_q == 16'd0)));

  // Pending and hold-off next state; a new event in the accept cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (hw_event) begin
      pending_d = 1'b1;
    end else if (accept) begin
      pending_d = 1'b0;
    end

    holdoff_d = holdoff_q;
    if (accept) begin
      holdoff_d = HoldoffLoad;
    end else if (holdoff_q != 16'd0) begin
      holdoff_d = holdoff_q - 16'd1;
    end
  end

  // FSM next state and registered request/ack outputs.
  always_comb begin
    state_d      = state_q;
    cfg_int_n_d  = 1'b1;
    ack_d        = 1'b0;
    resend_svc_d = resend_svc_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d      = StReq;
          cfg_int_n_d  = 1'b0;
          resend_svc_d = resend_interrupt;
        end
      end
      StReq: begin
        // Request is never withdrawn, even if the enables drop.
        if (accept) begin
          state_d = StGuard;
          ack_d   = resend_svc_q;
        end else begin
          cfg_int_n_d = 1'b0;
        end
      end
      StGuard: begin
        // One cycle for hw_sw_synch to drop resend_interrupt after the ack.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cfg_int_n_q  <= 1'b1;
      ack_q        <= 1'b0;
      resend_svc_q <= 1'b0;
      pending_q    <= 1'b0;
      holdoff_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      cfg_int_n_q  <= cfg_int_n_d;
      ack_q        <= ack_d;
      resend_svc_q <= resend_svc_d;
      pending_q    <= pending_d;
      holdoff_q    <= holdoff_d;
    end
  end

  // Accepted-MSI counter; only written on acceptance, wraps naturally.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_interrupt_gen.sv
// Directed self-checking bench for interrupt_gen (HOLDOFF_CYCLES = 8).
module tb_interrupt_gen;

  logic        trn_clk;
  logic        reset;
  logic        hw_event;
  logic        interrupts_enabled;
  logic        resend_interrupt;
  logic        resend_interrupt_ack;
  logic        cfg_interrupt_msienable;
  logic        cfg_interrupt_rdy_n;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_assert_n;
  logic [7:0]  cfg_interrupt_di;
  logic [31:0] interrupt_count;

  int tests;
  int failed;
  int cyc;
  int launches;
  int acks;
  bit prev_n = 1'b1;

  interrupt_gen #(
    .HOLDOFF_CYCLES(8)
  ) dut (
    .trn_clk                (trn_clk),
    .reset                  (reset),
    .hw_event               (hw_event),
    .interrupts_enabled     (interrupts_enabled),
    .resend_interrupt       (resend_interrupt),
    .resend_interrupt_ack   (resend_interrupt_ack),
    .cfg_interrupt_msienable(cfg_interrupt_msienable),
    .cfg_interrupt_rdy_n    (cfg_interrupt_rdy_n),
    .cfg_interrupt_n        (cfg_interrupt_n),
    .cfg_interrupt_assert_n (cfg_interrupt_assert_n),
    .cfg_interrupt_di       (cfg_interrupt_di),
    .interrupt_count        (interrupt_count)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  // Count MSI launches (falling edges of cfg_interrupt_n) and ack cycles.
  always @(negedge trn_clk) begin
    prev_n <= cfg_interrupt_n;
    if (!reset && prev_n && !cfg_interrupt_n) launches <= launches + 1;
    if (!reset && resend_interrupt_ack) acks <= acks + 1;
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    int i;
    i = 0;
    while (cfg_interrupt_n !== 1'b0 && i < max_cycles) begin
      tick();
      i++;
    end
    if (cfg_interrupt_n !== 1'b0) begin
      tests++;
      failed++;
      $error("FAIL %s: observed no request, required request within %0d cycles", tag,
             max_cycles);
    end
  endtask

  task automatic pulse_event();
    hw_event = 1'b1;
    tick();
    hw_event = 1'b0;
  endtask

  initial begin
    int c1;
    int l0;
    int a0;
    logic [31:0] n0;
    bit all_low;

    reset = 1'b1;
    hw_event = 1'b0;
    interrupts_enabled = 1'b1;
    resend_interrupt = 1'b0;
    cfg_interrupt_msienable = 1'b1;
    cfg_interrupt_rdy_n = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_cfg_n", 32'(cfg_interrupt_n), 32'd1);
    check("rst_assert_n", 32'(cfg_interrupt_assert_n), 32'd1);
    check("rst_di", 32'(cfg_interrupt_di), 32'd0);
    check("rst_ack", 32'(resend_interrupt_ack), 32'd0);
    check("rst_count", interrupt_count, 32'd0);
    check("rst_pending", 32'(dut.pending_q), 32'd0);

    // Hold-off with a single event
    l0 = launches;
    a0 = acks;
    pulse_event();
    check("s1_pending_set", 32'(dut.pending_q), 32'd1);
    tick();
    check("s1_launch", 32'(cfg_interrupt_n), 32'd0);
    tick();
    check("s1_hold", 32'(cfg_interrupt_n), 32'd0);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    c1 = cyc;
    check("s1_cfg_n_rel", 32'(cfg_interrupt_n), 32'd1);
    check("s1_count", interrupt_count, 32'd1);
    check("s1_pending_clr", 32'(dut.pending_q), 32'd0);
    check("s1_no_ack", 32'(resend_interrupt_ack), 32'd0);
    tick();
    tick();
    pulse_event();
    wait_req("s1_wait2", 30);
    check("s1_holdoff_spacing", 32'(cyc - c1), 32'd9);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    check("s1_count2", interrupt_count, 32'd2);
    tick();
    tick();
    check("s1_launches", 32'(launches - l0), 32'd2);
    check("s1_acks", 32'(acks - a0), 32'd0);

    // Interrupts disabled, resend still serviced
    interrupts_enabled = 1'b0;
    l0 = launches;
    a0 = acks;
    for (int i = 0; i < 5; i++) begin
      pulse_event();
      tick();
    end
    tick();
    tick();
    check("s2_no_msi", 32'(launches - l0), 32'd0);
    check("s2_pending", 32'(dut.pending_q), 32'd1);
    resend_interrupt = 1'b1;
    tick();
    check("s2_launch", 32'(cfg_interrupt_n), 32'd0);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    check("s2_ack", 32'(resend_interrupt_ack), 32'd1);
    check("s2_pending_clr", 32'(dut.pending_q), 32'd0);
    check("s2_count", interrupt_count, 32'd3);
    resend_interrupt = 1'b0;
    tick();
    check("s2_ack_drop", 32'(resend_interrupt_ack), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("s2_single_msi", 32'(launches - l0), 32'd1);
    check("s2_single_ack", 32'(acks - a0), 32'd1);

    // Resend during an in-flight normal request
    interrupts_enabled = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    a0 = acks;
    n0 = interrupt_count;
    pulse_event();
    tick();
    check("s3_launch", 32'(cfg_interrupt_n), 32'd0);
    resend_interrupt = 1'b1;
    tick();
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    check("s3_first_no_ack", 32'(resend_interrupt_ack), 32'd0);
    tick();
    check("s3_guard_idle", 32'(cfg_interrupt_n), 32'd1);
    tick();
    check("s3_second_launch", 32'(cfg_interrupt_n), 32'd0);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    check("s3_second_ack", 32'(resend_interrupt_ack), 32'd1);
    resend_interrupt = 1'b0;
    tick();
    check("s3_ack_once", 32'(acks - a0), 32'd1);
    check("s3_count", interrupt_count - n0, 32'd2);

    // Event coincident with acceptance, then request held under stall
    for (int i = 0; i < 10; i++) tick();
    n0 = interrupt_count;
    pulse_event();
    tick();
    check("s4_launch", 32'(cfg_interrupt_n), 32'd0);
    hw_event = 1'b1;
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    hw_event = 1'b0;
    cfg_interrupt_rdy_n = 1'b1;
    check("s4_pending_kept", 32'(dut.pending_q), 32'd1);
    check("s4_count1", interrupt_count - n0, 32'd1);
    wait_req("s4_wait", 30);
    cfg_interrupt_msienable = 1'b0;
    all_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_interrupt_n !== 1'b0) all_low = 1'b0;
    end
    check("s4_stall_hold", 32'(all_low), 32'd1);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    cfg_interrupt_msienable = 1'b1;
    check("s4_count2", interrupt_count - n0, 32'd2);
    check("s4_rel", 32'(cfg_interrupt_n), 32'd1);
    tick();
    tick();

    // Reset mid-request
    a0 = acks;
    pulse_event();
    wait_req("s5_wait", 30);
    reset = 1'b1;
    tick();
    check("s5_cfg_n", 32'(cfg_interrupt_n), 32'd1);
    check("s5_ack", 32'(resend_interrupt_ack), 32'd0);
    check("s5_count", interrupt_count, 32'd0);
    check("s5_assert_n", 32'(cfg_interrupt_assert_n), 32'd1);
    check("s5_di", 32'(cfg_interrupt_di), 32'd0);
    check("s5_pending", 32'(dut.pending_q), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("s5_no_ack", 32'(acks - a0), 32'd0);

    // Counter wrap
    force dut.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.count_q;
    check("s6_preload", interrupt_count, 32'hFFFF_FFFF);
    pulse_event();
    tick();
    check("s6_launch", 32'(cfg_interrupt_n), 32'd0);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    check("s6_wrap", interrupt_count, 32'h0000_0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
